// File: rtl/lcrc_pkg.sv
// Shared constants, FSM state type and the bytewise reflected CRC-32 step
// used by the lcrc_stream engine.
package lcrc_pkg;

  localparam logic [31:0] LCRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] LCRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] LCRC_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] LCRC_RESIDUE   = 32'hDEBB20E3;
  // The register shifts right, so the polynomial is applied bit-reversed.
  localparam logic [31:0] LCRC_POLY_REFL = {<<{LCRC_POLY}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } lcrc_state_e;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int b = 0; b < 8; b++) begin
      if (c[0]) begin
        c = {1'b0, c[31:1]} ^ LCRC_POLY_REFL;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/lcrc_lane_tree.sv
// Combinational chain of per-lane CRC byte steps; lane 0 is folded in first
// and disabled lanes pass the running value through untouched.
module lcrc_lane_tree import lcrc_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [31:0]         crc_in,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] lane_en,
  output logic [31:0]         crc_out
);

  localparam int LANES = DATA_W / 8;

  // Fold the enabled bytes in lane order.
  always_comb begin
    logic [31:0] crc_v;
    crc_v = crc_in;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        crc_v = crc_byte(crc_v, data[8*i +: 8]);
      end else begin
        crc_v = crc_v;
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/lcrc_stream.sv
// Streaming CRC-32 generate/check engine with sop/eop framing, partial last
// beats, framing-violation reporting and saturating frame/error counters.
module lcrc_stream import lcrc_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                check_en,
  output logic [31:0]         out,
  output logic                crc_valid,
  output logic                crc_ok,
  output logic                crc_err,
  output logic                busy,
  output logic                proto_err,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int             LANES   = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  lcrc_state_e       state_r;
  logic [31:0]       crc_r;
  logic              check_r;
  logic [31:0]       out_r;
  logic              crc_valid_r, crc_ok_r, crc_err_r, busy_r, proto_err_r;
  logic [CNT_W-1:0]  frame_cnt_r, err_cnt_r;

  logic [LANES-1:0]  prefix_s, lane_en_s;
  logic              keep_bad_s, take_s, restart_s, mode_s, pass_s;
  logic [31:0]       seed_s, next_crc_s;

  // Beat decode: usable keep prefix, lane enables, seed and framing checks.
  always_comb begin
    logic run_v;
    run_v = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      run_v       = run_v & in_keep[i];
      prefix_s[i] = run_v;
    end
    if (in_eop) begin
      lane_en_s = prefix_s;
    end else begin
      lane_en_s = {LANES{1'b1}};
    end
    if (in_sop) begin
      seed_s = LCRC_INIT;
      mode_s = check_en;
    end else begin
      seed_s = crc_r;
      mode_s = check_r;
    end
    keep_bad_s = in_valid & in_eop & ((prefix_s != in_keep) | ~(|prefix_s));
    take_s     = in_valid & (in_sop | (state_r == ST_FRAME));
    restart_s  = in_valid & in_sop & (state_r == ST_FRAME);
    pass_s     = (next_crc_s == LCRC_RESIDUE);
  end

  lcrc_lane_tree #(.DATA_W(DATA_W)) u_tree (
    .crc_in  (seed_s),
    .data    (in_data),
    .lane_en (lane_en_s),
    .crc_out (next_crc_s)
  );

  // Framing FSM, CRC register, result registers and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      crc_r       <= LCRC_INIT;
      check_r     <= 1'b0;
      out_r       <= 32'h00000000;
      crc_valid_r <= 1'b0;
      crc_ok_r    <= 1'b0;
      crc_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      proto_err_r <= 1'b0;
      frame_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      crc_valid_r <= 1'b0;
      proto_err_r <= 1'b0;
      if (take_s) begin
        proto_err_r <= keep_bad_s | restart_s;
        check_r     <= mode_s;
        if (in_eop) begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          crc_r       <= LCRC_INIT;
          crc_valid_r <= 1'b1;
          out_r       <= next_crc_s ^ LCRC_XOROUT;
          crc_ok_r    <= mode_s & pass_s;
          crc_err_r   <= mode_s & ~pass_s;
          if (frame_cnt_r != CNT_MAX) begin
            frame_cnt_r <= frame_cnt_r + CNT_ONE;
          end else begin
            frame_cnt_r <= frame_cnt_r;
          end
          if (mode_s && !pass_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
          end else begin
            err_cnt_r <= err_cnt_r;
          end
        end else begin
          state_r <= ST_FRAME;
          busy_r  <= 1'b1;
          crc_r   <= next_crc_s;
        end
      end else if (in_valid) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= 1'b0;
      end
    end
  end

  assign out       = out_r;
  assign crc_valid = crc_valid_r;
  assign crc_ok    = crc_ok_r;
  assign crc_err   = crc_err_r;
  assign busy      = busy_r;
  assign proto_err = proto_err_r;
  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;

endmodule
